// File: rtl/sweep_mon_pkg.sv
// rtl/sweep_mon_pkg.sv - shared state encoding and signature step for the sweep monitor
package sweep_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } mon_state_t;

    localparam int              SIG_W    = 16;
    localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;

    // One MISR step: CRC-16/CCITT-style shift, then fold in the response word.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] data);
        logic [SIG_W-1:0] shifted;
        shifted = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0);
        return shifted ^ data;
    endfunction

endpackage

// File: rtl/sweep_sig_misr.sv
// rtl/sweep_sig_misr.sv - 16-bit response signature register with seed load
module sweep_sig_misr
    import sweep_mon_pkg::*;
#(
    parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [SIG_W-1:0] i_data,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;

    // Load outranks enable so a restart never folds in a same-cycle sample.
    always_ff @(posedge clk) begin
        if (!rst_n || i_load) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= sig_step(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/sweep_response_monitor.sv
// rtl/sweep_response_monitor.sv - checks an in-order 0..2^WIDTH-1 sweep and signs the responses
module sweep_response_monitor
    import sweep_mon_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             smp_valid,
    input  logic [WIDTH-1:0] smp_in,
    input  logic [WIDTH-1:0] smp_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_index,
    output logic [WIDTH:0]   count,
    output logic [SIG_W-1:0] signature
);

    localparam logic [WIDTH:0] LAST = (WIDTH+1)'((1 << WIDTH) - 1);

    mon_state_t       r_state;
    // Accepted count and expected stimulus advance together, so one register serves both.
    logic [WIDTH:0]   r_count;
    logic [WIDTH-1:0] r_err_index;

    logic             w_run;
    logic             w_hit;
    logic             w_accept;
    logic             w_miss;
    logic [SIG_W-1:0] w_data;

    assign w_run    = (r_state == ST_RUN);
    assign w_hit    = ({1'b0, smp_in} == r_count);
    assign w_accept = w_run && !start && smp_valid && w_hit;
    assign w_miss   = w_run && !start && smp_valid && !w_hit;
    assign w_data   = SIG_W'(smp_out);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_err_index <= '0;
        end else if (start) begin
            r_state     <= ST_RUN;
            r_count     <= '0;
            r_err_index <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 1'b1;
            if (r_count == LAST) begin
                r_state <= ST_DONE;
            end
        end else if (w_miss) begin
            r_state     <= ST_ERROR;
            r_err_index <= r_count[WIDTH-1:0];
        end
    end

    sweep_sig_misr #(
        .SEED (SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (start),
        .i_en   (w_accept),
        .i_data (w_data),
        .o_sig  (signature)
    );

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign err       = (r_state == ST_ERROR);
    assign err_index = r_err_index;
    assign count     = r_count;

endmodule
